// File: rtl/tb_uart_rx_mon.sv
// rtl/tb_uart_rx_mon.sv - UART receive monitor: 8-bit LSB-first frames into a FWFT FIFO
// Frames carry optional parity; each entry is {perr, ferr, data}, and the monitor keeps saturating frame/error counters.
module tb_uart_rx_mon #(
   parameter int CLK_DIV    = 868,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        tb_clk,
   input  logic        tb_rst_n,
   input  logic        rxd,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_perr,
   output logic        rx_ferr,
   input  logic        ovf_clr,
   output logic        overflow,
   output logic        busy,
   output logic [15:0] byte_cnt,
   output logic [15:0] err_cnt
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);
   localparam logic PEN  = (PARITY_EN != 0);
   localparam logic PODD = (PARITY_ODD != 0);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK} state_t;

   state_t          state, state_nx;
   logic            s1, rs;
   logic [CW-1:0]   bit_cnt, bit_cnt_nx;
   logic [2:0]      idx, idx_nx;
   logic [7:0]      shreg, shreg_nx;
   logic            perr, perr_nx;
   logic            push, sample;

   logic [9:0]      mem [FIFO_DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            empty, full, pop, wr_en;
   logic [9:0]      head;

   always_ff @(posedge tb_clk or negedge tb_rst_n) begin
      if (!tb_rst_n) begin
         s1 <= 1'b1;
         rs <= 1'b1;
      end else begin
         s1 <= rxd;
         rs <= s1;
      end
   end

   assign sample = (bit_cnt == '0);

   always_ff @(posedge tb_clk or negedge tb_rst_n) begin
      if (!tb_rst_n) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         idx     <= '0;
         shreg   <= '0;
         perr    <= 1'b0;
      end else begin
         state   <= state_nx;
         bit_cnt <= bit_cnt_nx;
         idx     <= idx_nx;
         shreg   <= shreg_nx;
         perr    <= perr_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      bit_cnt_nx = sample ? bit_cnt : bit_cnt - 1'b1;
      idx_nx     = idx;
      shreg_nx   = shreg;
      perr_nx    = perr;
      push       = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rs) begin
               bit_cnt_nx = HALF_LOAD;
               state_nx   = S_START;
            end
         end
         S_START: begin
            if (sample) begin
               if (!rs) begin
                  bit_cnt_nx = FULL_LOAD;
                  idx_nx     = '0;
                  perr_nx    = 1'b0;
                  state_nx   = S_DATA;
               end else begin
                  state_nx   = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (sample) begin
               shreg_nx   = {rs, shreg[7:1]};
               bit_cnt_nx = FULL_LOAD;
               idx_nx     = idx + 3'd1;
               if (idx == 3'd7) state_nx = PEN ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (sample) begin
               perr_nx    = rs ^ (^shreg) ^ PODD;
               bit_cnt_nx = FULL_LOAD;
               state_nx   = S_STOP;
            end
         end
         S_STOP: begin
            if (sample) begin
               push     = 1'b1;
               state_nx = rs ? S_IDLE : S_BRK;
            end
         end
         S_BRK: begin
            // Hold here through a break so a low line cannot look like a new start bit.
            if (rs) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign busy     = (state != S_IDLE);
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
   assign rx_valid = !empty;
   assign pop      = rx_valid && rx_ready;
   assign wr_en    = push && (!full || pop);
   assign head     = mem[rd_ptr[AW-1:0]];
   assign rx_data  = rx_valid ? head[7:0] : 8'h00;
   assign rx_ferr  = rx_valid & head[8];
   assign rx_perr  = rx_valid & head[9];

   always_ff @(posedge tb_clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {perr, ~rs, shreg};
   end

   always_ff @(posedge tb_clk or negedge tb_rst_n) begin
      if (!tb_rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         byte_cnt <= '0;
         err_cnt  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (push && full && !pop) overflow <= 1'b1;
         else if (ovf_clr)         overflow <= 1'b0;
         if (push) begin
            if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
            if ((perr || !rs) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_tb_uart_rx_mon.sv
// tb/tb_tb_uart_rx_mon.sv - self-checking bench for tb_uart_rx_mon with a queue-based frame model
// Frames are built bit by bit at the serial level; expectations come from the frame rules, not the receiver's structure.
module tb_tb_uart_rx_mon;
   localparam int CLK_DIV = 16;
   localparam int DEPTH   = 16;

   logic        tb_clk = 1'b0;
   logic        tb_rst_n = 1'b0;
   logic        rxd = 1'b1;
   logic        rx_ready = 1'b0;
   logic        ovf_clr = 1'b0;
   logic        rx_valid, rx_perr, rx_ferr, overflow, busy;
   logic [7:0]  rx_data;
   logic [15:0] byte_cnt, err_cnt;

   int checks = 0;
   int failures = 0;

   logic [9:0] exp_q [$];
   int         m_bytes = 0;
   int         m_errs = 0;
   logic       m_ovf = 1'b0;

   tb_uart_rx_mon #(.CLK_DIV(CLK_DIV), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) dut (
      .tb_clk(tb_clk), .tb_rst_n(tb_rst_n), .rxd(rxd),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .rx_perr(rx_perr), .rx_ferr(rx_ferr), .ovf_clr(ovf_clr),
      .overflow(overflow), .busy(busy), .byte_cnt(byte_cnt), .err_cnt(err_cnt)
   );

   always #5 tb_clk = ~tb_clk;

   initial begin
      #5ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge tb_clk);
         #1;
      end
   endtask

   task automatic model_frame(input logic [7:0] d, input logic pe, input logic fe);
      if (m_bytes < 65535) m_bytes++;
      if ((pe || fe) && m_errs < 65535) m_errs++;
      if (exp_q.size() < DEPTH) exp_q.push_back({pe, fe, d});
      else m_ovf = 1'b1;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_bytes = 0;
      m_errs = 0;
      m_ovf = 1'b0;
   endtask

   // Even parity on the line: correct parity bit is the XOR of the data bits.
   task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop_bad, input int low_hold);
      logic pbit;
      pbit = (^d) ^ par_bad;
      rxd = 1'b0;
      tick(CLK_DIV);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         tick(CLK_DIV);
      end
      rxd = pbit;
      tick(CLK_DIV);
      if (stop_bad) begin
         rxd = 1'b0;
         tick(CLK_DIV * (1 + low_hold));
         check("brk_busy", 32'(busy), 32'd1);
      end else begin
         rxd = 1'b1;
         tick(CLK_DIV);
      end
      rxd = 1'b1;
      tick(CLK_DIV * 2);
      model_frame(d, pbit != (^d), stop_bad);
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_byte_cnt"}, 32'(byte_cnt), 32'(m_bytes));
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_errs));
      check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
   endtask

   task automatic drain(input string tag);
      logic [9:0] e;
      int w;
      while (exp_q.size() > 0) begin
         w = 0;
         while (!rx_valid && w < 100) begin
            tick(1);
            w++;
         end
         check({tag, "_valid"}, 32'(rx_valid), 32'd1);
         e = exp_q.pop_front();
         check({tag, "_data"}, 32'(rx_data), 32'(e[7:0]));
         check({tag, "_ferr"}, 32'(rx_ferr), 32'(e[8]));
         check({tag, "_perr"}, 32'(rx_perr), 32'(e[9]));
         rx_ready = 1'b1;
         tick(1);
         rx_ready = 1'b0;
      end
      check({tag, "_empty"}, 32'(rx_valid), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(rx_valid), 32'd0);
      check({tag, "_outs"}, {rx_data, rx_perr, rx_ferr, overflow, busy}, 32'd0);
      check({tag, "_cnts"}, {byte_cnt, err_cnt}, 32'd0);
   endtask

   initial begin
      logic [7:0] d;
      logic       pb, sb;
      tick(3);
      check_all_zero("reset");
      tb_rst_n = 1'b1;
      tick(4);

      send_frame(8'h55, 1'b0, 1'b0, 0);
      check_counters("f55");
      drain("f55");

      send_frame(8'hA3, 1'b1, 1'b0, 0);
      check_counters("fA3");
      drain("fA3");
      send_frame(8'h00, 1'b0, 1'b0, 0);
      check_counters("f00");
      drain("f00");

      send_frame(8'h3C, 1'b0, 1'b1, 2);
      check("brk_idle", 32'(busy), 32'd0);
      check_counters("f3C");
      drain("f3C");

      rxd = 1'b0;
      tick(5);
      check("glitch_busy", 32'(busy), 32'd1);
      rxd = 1'b1;
      tick(CLK_DIV * 3);
      check("glitch_idle", 32'(busy), 32'd0);
      check("glitch_valid", 32'(rx_valid), 32'd0);
      check_counters("glitch");

      for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b0, 1'b0, 0);
      check_counters("ovf");
      drain("ovf");
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      m_ovf = 1'b0;
      check_counters("ovf_clr");

      for (int n = 0; n < 24; n++) begin
         d  = 8'($urandom);
         pb = ($urandom_range(3) == 0);
         sb = ($urandom_range(5) == 0);
         send_frame(d, pb, sb, int'($urandom_range(2, 1)));
         if (exp_q.size() >= 4 || $urandom_range(1) == 1) begin
            check_counters("rnd");
            drain("rnd");
         end
      end
      check_counters("rnd_end");
      drain("rnd_end");

      rxd = 1'b0;
      tick(CLK_DIV);
      d = 8'hF0;
      for (int i = 0; i < 4; i++) begin
         rxd = d[i];
         tick(CLK_DIV);
      end
      rxd = d[4];
      tick(CLK_DIV / 2);
      tb_rst_n = 1'b0;
      rxd = 1'b1;
      tick(2);
      check_all_zero("midrst");
      model_reset();
      tb_rst_n = 1'b1;
      tick(CLK_DIV * 2);
      check_all_zero("post_rst");
      send_frame(8'h81, 1'b0, 1'b0, 0);
      check_counters("f81");
      drain("f81");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
